// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Encoding of the core-bus rw bit.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of a requester index; at least one bit so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin selector: the first set request at or above
// ptr, searching upward and wrapping back to requester 0.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]                req,
  input  logic [idx_width(NREQ)-1:0]     ptr,
  output logic                           any,
  output logic [idx_width(NREQ)-1:0]     idx
);

  localparam int PW = idx_width(NREQ);

  logic [PW-1:0] w_j;

  // Walk the requesters in priority order and keep the first hit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    any = 1'b0;
    idx = '0;
    w_j = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = PW'((int'(ptr) + k) % NREQ);
      if (!any && req[w_j]) begin
        any = 1'b1;
        idx = w_j;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NREQ core-bus
// masters. One access at a time: latch the winner, drive the memory port
// until ready or timeout, pulse the winner's done, then rotate priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_done,
  output logic              req_err,
  output logic [DW-1:0]     rdata,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ready,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int PW = idx_width(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  // The wait counter stops here; it never needs to wrap.
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  arb_state_e    r_state;
  arb_state_e    w_next_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_grant;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [TW-1:0] r_tcnt;
  logic          r_err;
  logic [DW-1:0] r_rdata;

  logic          w_any;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_ptr_next;
  logic          w_terminal;

  mem_arb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (r_ptr),
    .any  (w_any),
    .idx  (w_idx)
  );

  assign w_ptr_next = (r_grant == PW'(NREQ - 1)) ? '0 : r_grant + PW'(1);
  assign w_terminal = (r_tcnt == TCNT_LAST);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see pre-edge values, whatever order the statements are in.
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode; a ready on the terminal count still completes cleanly.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = ISSUE;
      ISSUE:   if (mem_ready || w_terminal) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the winner, count wait cycles, capture the response, rotate ptr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_rw    <= RW_WRITE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_idx;
            r_rw    <= req_rw[w_idx];
            r_addr  <= req_addr[w_idx*AW +: AW];
            r_wdata <= req_wdata[w_idx*DW +: DW];
            r_tcnt  <= '0;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            r_rdata <= (r_rw == RW_READ) ? mem_rdata : '0;
            r_err   <= 1'b0;
          end else if (w_terminal) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_tcnt  <= r_tcnt + TW'(1);
          end
        end
        RESP: r_ptr <= w_ptr_next;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_done = '0;
    if (r_state == RESP) req_done[r_grant] = 1'b1;
    req_err   = (r_state == RESP) && r_err;
    mem_valid = (r_state == ISSUE);
    busy      = (r_state != IDLE);
  end

  assign mem_rw    = r_rw;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// reset-in-flight sequence, then randomized traffic against a
// transaction-level model of the round-robin rules.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_rw = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_done;
  logic              req_err;
  logic [DW-1:0]     rdata;
  logic              mem_valid;
  logic              mem_rw;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  // Requester-side view: what each master is presenting.
  logic [N-1:0]  want_valid;
  logic [AW-1:0] t_addr  [N];
  logic [DW-1:0] t_wdata [N];
  logic          t_rw    [N];
  int            m_ptr;

  typedef struct {
    logic [N-1:0] valid;
    logic         rw;
    logic [63:0]  base;
    logic [63:0]  wdata;
    int           wt;
    logic [63:0]  mrd;
    int           grant;
    logic         err;
    logic [63:0]  rd;
    bit           scr;
  } vec_t;

  vec_t tab [9];

  mem_arbiter #(
    .NREQ    (N),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply();
    req_valid = want_valid;
    for (int i = 0; i < N; i++) begin
      req_rw[i]              = t_rw[i];
      req_addr[i*AW +: AW]   = t_addr[i];
      req_wdata[i*DW +: DW]  = t_wdata[i];
    end
  endtask

  task automatic new_fields(input int i);
    t_addr[i]  = {$urandom, $urandom};
    t_wdata[i] = {$urandom, $urandom};
    t_rw[i]    = 1'($urandom_range(0, 1));
  endtask

  task automatic check_idle();
    check("idle_mem_valid", 64'(mem_valid), 64'd0);
    check("idle_busy",      64'(busy),      64'd0);
    check("idle_req_done",  64'(req_done),  64'd0);
    check("idle_req_err",   64'(req_err),   64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_done"},  64'(req_done),  64'd0);
    check({tag, "_req_err"},   64'(req_err),   64'd0);
    check({tag, "_rdata"},     rdata,          64'd0);
    check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    check({tag, "_mem_rw"},    64'(mem_rw),    64'd0);
    check({tag, "_mem_addr"},  mem_addr,       64'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  // Round-robin rule: first valid requester at or after p, wrapping.
  function automatic int rr_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Called in an IDLE cycle whose inputs already request service. The
  // memory answers after wt wait cycles (never, if wt >= TO). Ends in the
  // response cycle after checking done/err/rdata.
  task automatic run_txn(input int g, input logic rw, input logic [63:0] addr,
                         input logic [63:0] wdata, input int wt,
                         input logic [63:0] mrd, input logic exp_err,
                         input logic [63:0] exp_rd, input bit scramble);
    int len;
    logic [N-1:0] exp_done;
    len = (wt < TO) ? wt + 1 : TO;
    exp_done = '0;
    exp_done[g] = 1'b1;
    tick();
    for (int i = 0; i < len; i++) begin
      check("issue_mem_valid", 64'(mem_valid), 64'd1);
      check("issue_busy",      64'(busy),      64'd1);
      check("issue_mem_addr",  mem_addr,       addr);
      check("issue_mem_wdata", mem_wdata,      wdata);
      check("issue_mem_rw",    64'(mem_rw),    64'(rw));
      check("issue_req_done",  64'(req_done),  64'd0);
      if (scramble && i == 0) begin
        req_valid = N'($urandom);
        req_rw    = N'($urandom);
        req_addr  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      mem_ready = (wt < TO) && (i == wt);
      mem_rdata = (i == wt) ? mrd : {$urandom, $urandom};
      tick();
    end
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    check("resp_mem_valid", 64'(mem_valid), 64'd0);
    check("resp_busy",      64'(busy),      64'd1);
    check("resp_req_done",  64'(req_done),  64'(exp_done));
    check("resp_req_err",   64'(req_err),   64'(exp_err));
    check("resp_rdata",     rdata,          exp_rd);
  endtask

  task automatic load_vec(input int i);
    want_valid = tab[i].valid;
    for (int r = 0; r < N; r++) begin
      t_rw[r]    = tab[i].rw;
      t_addr[r]  = tab[i].base + 64'(r) * 64'h1000;
      t_wdata[r] = tab[i].wdata + 64'(r);
    end
  endtask

  initial begin
    int g, wt;
    logic [63:0] mrd;
    logic e;

    tab[0] = '{valid: 3'b001, rw: 1'b1, base: 64'h10,  wdata: 64'h0,  wt: 0, mrd: 64'hDEADBEEF, grant: 0, err: 1'b0, rd: 64'hDEADBEEF, scr: 1'b0};
    tab[1] = '{valid: 3'b011, rw: 1'b1, base: 64'h100, wdata: 64'h0,  wt: 0, mrd: 64'h1111,     grant: 1, err: 1'b0, rd: 64'h1111,     scr: 1'b0};
    tab[2] = '{valid: 3'b011, rw: 1'b1, base: 64'h200, wdata: 64'h0,  wt: 1, mrd: 64'h2222,     grant: 0, err: 1'b0, rd: 64'h2222,     scr: 1'b0};
    tab[3] = '{valid: 3'b011, rw: 1'b1, base: 64'h300, wdata: 64'h0,  wt: 0, mrd: 64'h3333,     grant: 1, err: 1'b0, rd: 64'h3333,     scr: 1'b0};
    tab[4] = '{valid: 3'b010, rw: 1'b0, base: 64'h20,  wdata: 64'h55, wt: 3, mrd: 64'h9999,     grant: 1, err: 1'b0, rd: 64'h0,        scr: 1'b0};
    tab[5] = '{valid: 3'b111, rw: 1'b1, base: 64'h400, wdata: 64'h0,  wt: 4, mrd: 64'h7777,     grant: 2, err: 1'b1, rd: 64'h0,        scr: 1'b1};
    tab[6] = '{valid: 3'b110, rw: 1'b1, base: 64'h500, wdata: 64'h0,  wt: 2, mrd: 64'h6666,     grant: 1, err: 1'b0, rd: 64'h6666,     scr: 1'b1};
    tab[7] = '{valid: 3'b101, rw: 1'b0, base: 64'h600, wdata: 64'hAA, wt: 0, mrd: 64'h5555,     grant: 2, err: 1'b0, rd: 64'h0,        scr: 1'b0};
    tab[8] = '{valid: 3'b101, rw: 1'b1, base: 64'h700, wdata: 64'h0,  wt: 5, mrd: 64'h4444,     grant: 0, err: 1'b1, rd: 64'h0,        scr: 1'b0};

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      load_vec(i);
      apply();
      if (i > 0) begin
        tick();
        check_idle();
      end
      run_txn(tab[i].grant, tab[i].rw,
              tab[i].base + 64'(tab[i].grant) * 64'h1000,
              tab[i].wdata + 64'(tab[i].grant),
              tab[i].wt, tab[i].mrd, tab[i].err, tab[i].rd, tab[i].scr);
    end

    // Reset during ISSUE: ptr is 1 here, so requester 1 is granted first.
    want_valid = 3'b011;
    for (int r = 0; r < N; r++) begin
      t_rw[r] = 1'b1;
      t_addr[r] = 64'h800 + 64'(r) * 64'h1000;
      t_wdata[r] = 64'h0;
    end
    apply();
    tick();
    check_idle();
    tick();
    check("pre_reset_mem_valid", 64'(mem_valid), 64'd1);
    check("pre_reset_mem_addr",  mem_addr, 64'h1800);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    tick();
    check_all_zero("held_reset");
    reset = 1'b1;
    run_txn(0, 1'b1, 64'h800, 64'h0, 0, 64'hCAFE, 1'b0, 64'hCAFE, 1'b0);
    m_ptr = 1;

    // Randomized traffic.
    want_valid = N'($urandom);
    for (int r = 0; r < N; r++) new_fields(r);
    apply();
    tick();
    check_idle();
    for (int t = 0; t < 150; t++) begin
      if (want_valid == '0) begin
        tick();
        check_idle();
        want_valid = N'($urandom) & N'($urandom);
        for (int r = 0; r < N; r++) new_fields(r);
        apply();
        continue;
      end
      g   = rr_winner(want_valid, m_ptr);
      wt  = $urandom_range(0, TO + 1);
      mrd = {$urandom, $urandom};
      e   = (wt >= TO);
      run_txn(g, t_rw[g], t_addr[g], t_wdata[g], wt, mrd, e,
              (!e && t_rw[g]) ? mrd : 64'h0, 1'($urandom_range(0, 1)));
      m_ptr = (g + 1) % N;
      want_valid[g] = 1'($urandom_range(0, 1));
      for (int r = 0; r < N; r++) begin
        if (r == g) new_fields(r);
        else if (!want_valid[r]) begin
          new_fields(r);
          want_valid[r] = ($urandom_range(0, 3) == 0);
        end
      end
      apply();
      tick();
      check_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
